ej32_xu: RTL and testbench

Parametrised extended-arithmetic unit for the eJ32 datapath, the next generation of the current single-width extended unit. It executes multiply, multiply-high, signed/unsigned divide and remainder, and the three shifts on NOS/TOS operands. It uses one request/busy/done handshake, so the control FSM stalls on `bsy` and writes TOS on `done`. Divide is an in-block iterative restoring divider. Multiply is either single-cycle or iterative shift-add, selected by parameter.

---
 rtl/ej32_xu_pkg.sv | 37 +++
 rtl/ej32_xu_div.sv | 58 +++++
 rtl/ej32_xu.sv | 189 ++++++++++++++++++
 tb/tb_ej32_xu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ej32_xu_pkg.sv
// Shared types for the eJ32 extended-arithmetic unit: operation codes, FSM states
// and small op-class helpers used by the unit's decode.
package ej32_pkg;

    typedef enum logic [3:0] {
        XU_MUL  = 4'd0,
        XU_MULH = 4'd1,
        XU_DIV  = 4'd2,
        XU_REM  = 4'd3,
        XU_DIVU = 4'd4,
        XU_REMU = 4'd5,
        XU_SHL  = 4'd6,
        XU_SHR  = 4'd7,
        XU_USHR = 4'd8
    } xu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } xu_st_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == XU_DIV) || (op == XU_REM) || (op == XU_DIVU) || (op == XU_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == XU_MUL) || (op == XU_MULH);
    endfunction

    // Ops whose operands are reduced to magnitudes and sign-fixed afterwards.
    function automatic logic is_sgn_op(input logic [3:0] op);
        return (op == XU_MUL) || (op == XU_MULH) || (op == XU_DIV) || (op == XU_REM);
    endfunction

endpackage

// File: rtl/ej32_xu_div.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
// start loads operands and the step counter; last flags the final step.
module xu_seq_div
    import ej32_pkg::*;
#(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           step,
    input  logic [DSZ-1:0] dividend,
    input  logic [DSZ-1:0] divisor,
    output logic           last,
    output logic [DSZ-1:0] quo,
    output logic [DSZ-1:0] rem
);

    localparam int CW = $clog2(DSZ);

    logic [DSZ-1:0] dvs;
    logic [CW-1:0]  cnt;
    logic [DSZ:0]   partial;
    logic [DSZ:0]   trial;

    always_comb begin
        partial = {rem, quo[DSZ-1]};
        trial   = partial - {1'b0, dvs};
        last    = (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvs <= '0;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (start) begin
            dvs <= divisor;
            quo <= dividend;
            rem <= '0;
            cnt <= CW'(DSZ - 1);
        end else if (step) begin
            // A clear MSB in trial means the shifted remainder covers the divisor.
            if (!trial[DSZ]) begin
                rem <= trial[DSZ-1:0];
                quo <= {quo[DSZ-2:0], 1'b1};
            end else begin
                rem <= partial[DSZ-1:0];
                quo <= {quo[DSZ-2:0], 1'b0};
            end
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ej32_xu.sv
// eJ32 extended-arithmetic unit: multiply, divide/remainder and shifts on NOS/TOS
// behind a req/bsy/done handshake.
//   state | meaning
//   IDLE  | waiting for req
//   CALC  | one divide or shift-add step per cycle
//   FIX   | apply result signs
//   DONE  | done pulse, r/dz valid; may accept the next req
module ej32_xu
    import ej32_pkg::*;
#(
    parameter int DSZ     = 32,
    parameter int MUL_SEQ = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic [3:0]     op,
    input  logic [DSZ-1:0] a,
    input  logic [DSZ-1:0] b,
    input  logic           kill,
    output logic           bsy,
    output logic           done,
    output logic [DSZ-1:0] r,
    output logic           dz
);

    localparam int SW = $clog2(DSZ);

    xu_st_t           st;
    logic [3:0]       op_q;
    logic             neg_q;
    logic             neg_r;
    logic             sgn_op;
    logic             to_calc;
    logic             accept;
    logic             start;
    logic             step;
    logic             last;
    logic [SW-1:0]    sh;
    logic [DSZ-1:0]   mag_a;
    logic [DSZ-1:0]   mag_b;
    logic [DSZ-1:0]   quo;
    logic [DSZ-1:0]   rem;
    logic [DSZ-1:0]   imm_r;
    logic             imm_dz;
    logic [DSZ-1:0]   fix_r;
    logic [2*DSZ-1:0] prod_c;
    logic [2*DSZ-1:0] prod_s;
    logic [2*DSZ-1:0] prod_f;
    logic [DSZ-1:0]   mcand;
    logic [DSZ-1:0]   acc_hi;
    logic [DSZ-1:0]   acc_lo;
    logic [DSZ:0]     mul_sum;

    always_comb begin
        sh      = b[SW-1:0];
        sgn_op  = is_sgn_op(op);
        mag_a   = (sgn_op && a[DSZ-1]) ? -a : a;
        mag_b   = (sgn_op && b[DSZ-1]) ? -b : b;
        to_calc = (is_div_op(op) && (b != '0)) || (is_mul_op(op) && (MUL_SEQ != 0));
        accept  = req && !kill && ((st == IDLE) || (st == DONE));
        start   = accept && to_calc;
        step    = (st == CALC);
    end

    // Single-cycle results; divide ops only land here with a zero divisor.
    always_comb begin
        prod_c = {{DSZ{a[DSZ-1]}}, a} * {{DSZ{b[DSZ-1]}}, b};
        imm_r  = '0;
        imm_dz = 1'b0;
        case (op)
            XU_MUL:  imm_r = (MUL_SEQ == 0) ? prod_c[DSZ-1:0] : '0;
            XU_MULH: imm_r = (MUL_SEQ == 0) ? prod_c[2*DSZ-1:DSZ] : '0;
            XU_DIV, XU_DIVU: begin
                imm_r  = '1;
                imm_dz = 1'b1;
            end
            XU_REM, XU_REMU: begin
                imm_r  = a;
                imm_dz = 1'b1;
            end
            XU_SHL:  imm_r = a << sh;
            XU_SHR:  imm_r = $signed(a) >>> sh;
            XU_USHR: imm_r = a >> sh;
            default: imm_r = '0;
        endcase
    end

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        prod_s  = {acc_hi, acc_lo};
        prod_f  = neg_q ? -prod_s : prod_s;
        case (op_q)
            XU_MUL:          fix_r = prod_f[DSZ-1:0];
            XU_MULH:         fix_r = prod_f[2*DSZ-1:DSZ];
            XU_DIV, XU_DIVU: fix_r = neg_q ? -quo : quo;
            XU_REM, XU_REMU: fix_r = neg_r ? -rem : rem;
            default:         fix_r = '0;
        endcase
    end

    xu_seq_div #(.DSZ(DSZ)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .step     (step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .last     (last),
        .quo      (quo),
        .rem      (rem)
    );

    // Shift-add multiplier: the multiplier shifts out of acc_lo as product bits shift in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if (MUL_SEQ != 0) begin
            if (start) begin
                mcand  <= mag_a;
                acc_hi <= '0;
                acc_lo <= mag_b;
            end else if (step) begin
                {acc_hi, acc_lo} <= {mul_sum, acc_lo[DSZ-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= IDLE;
            bsy   <= 1'b0;
            done  <= 1'b0;
            r     <= '0;
            dz    <= 1'b0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q  <= op;
                        neg_q <= sgn_op && (a[DSZ-1] ^ b[DSZ-1]);
                        neg_r <= sgn_op && a[DSZ-1];
                        if (to_calc) begin
                            st  <= CALC;
                            bsy <= 1'b1;
                        end else begin
                            st   <= DONE;
                            done <= 1'b1;
                            r    <= imm_r;
                            dz   <= imm_dz;
                        end
                    end else begin
                        st <= IDLE;
                    end
                end
                CALC: begin
                    if (kill) begin
                        st  <= IDLE;
                        bsy <= 1'b0;
                    end else if (last) begin
                        st <= FIX;
                    end
                end
                FIX: begin
                    bsy <= 1'b0;
                    if (kill) begin
                        st <= IDLE;
                    end else begin
                        st   <= DONE;
                        done <= 1'b1;
                        r    <= fix_r;
                        dz   <= 1'b0;
                    end
                end
                default: begin
                    st  <= IDLE;
                    bsy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ej32_xu.sv
// Bench for ej32_xu: single-cycle and sequential-multiply instances driven in parallel,
// results compared against an integer-arithmetic reference model.
module tb_ej32_xu;
    import ej32_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        bsy0, done0, dz0;
    logic        bsy1, done1, dz1;
    logic [31:0] r0, r1;

    int n_chk = 0;
    int n_err = 0;

    ej32_xu #(.DSZ(32), .MUL_SEQ(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b), .kill(kill),
        .bsy(bsy0), .done(done0), .r(r0), .dz(dz0)
    );

    ej32_xu #(.DSZ(32), .MUL_SEQ(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b), .kill(kill),
        .bsy(bsy1), .done(done1), .r(r1), .dz(dz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic straight from the operation definitions.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input bit mseq, output logic [31:0] er, output logic edz,
                                  output int lat);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'd0, x});
        longint uy = longint'({32'd0, y});
        longint p  = 0;
        logic [4:0] s = y[4:0];
        er  = '0;
        edz = 1'b0;
        lat = 1;
        case (o)
            XU_MUL, XU_MULH: begin
                p   = sx * sy;
                er  = (o == XU_MUL) ? p[31:0] : p[63:32];
                lat = mseq ? 34 : 1;
            end
            XU_DIV, XU_REM, XU_DIVU, XU_REMU: begin
                if (y == 32'd0) begin
                    edz = 1'b1;
                    er  = ((o == XU_DIV) || (o == XU_DIVU)) ? 32'hFFFF_FFFF : x;
                end else begin
                    lat = 34;
                    if (o == XU_DIV)       p = sx / sy;
                    else if (o == XU_REM)  p = sx % sy;
                    else if (o == XU_DIVU) p = ux / uy;
                    else                   p = ux % uy;
                    er = p[31:0];
                end
            end
            XU_SHL:  er = x << s;
            XU_SHR:  er = $signed(x) >>> s;
            XU_USHR: er = x >> s;
            default: er = '0;
        endcase
    endfunction

    // Issue one op to both instances and wait (bounded) for each done.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int pulse_at, output logic [31:0] g0, output logic [31:0] g1);
        logic [31:0] e0, e1;
        logic        ed0, ed1;
        int          l0, l1;
        int          n;
        bit          s0, s1;
        model(o, x, y, 1'b0, e0, ed0, l0);
        model(o, x, y, 1'b1, e1, ed1, l1);
        g0 = '0;
        g1 = '0;
        @(negedge clk);
        req = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        req = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        s0 = 1'b0; s1 = 1'b0; n = 0;
        while (!(s0 && s1) && n < 45) begin
            @(negedge clk);
            n++;
            req = 1'b0;
            if (done0 && !s0) begin
                s0 = 1'b1;
                g0 = r0;
                chk("lat0", 64'(n), 64'(l0));
                chk("r0", 64'(r0), 64'(e0));
                chk("dz0", 64'(dz0), 64'(ed0));
            end
            if (done1 && !s1) begin
                s1 = 1'b1;
                g1 = r1;
                chk("lat1", 64'(n), 64'(l1));
                chk("r1", 64'(r1), 64'(e1));
                chk("dz1", 64'(dz1), 64'(ed1));
            end
            if (n == pulse_at) begin
                req = 1'b1; op = XU_SHL; a = 32'd1; b = 32'd3;
            end
        end
        chk("seen0", 64'(s0), 64'd1);
        chk("seen1", 64'(s1), 64'd1);
    endtask

    initial begin
        logic [31:0] g0, g1;
        logic [3:0]  bo[5];
        logic [31:0] bx[5], by[5];
        logic [31:0] e;
        logic        ed;
        int          lat;
        int          nd;

        rst_n = 1'b0; req = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_bsy", 64'({bsy0, bsy1}), 64'd0);
        chk("rst_done", 64'({done0, done1}), 64'd0);
        chk("rst_r", {r0, r1}, 64'd0);
        chk("rst_dz", 64'({dz0, dz1}), 64'd0);
        rst_n = 1'b1;

        run_op(XU_DIV, 32'hFFFF_FFF9, 32'd2, 0, g0, g1);
        chk("div_m7_2", {g0, g1}, {32'hFFFF_FFFD, 32'hFFFF_FFFD});
        run_op(XU_REM, 32'hFFFF_FFF9, 32'd2, 0, g0, g1);
        chk("rem_m7_2", {g0, g1}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        run_op(XU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, g0, g1);
        chk("div_ovf", {g0, g1}, {32'h8000_0000, 32'h8000_0000});
        run_op(XU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, g0, g1);
        chk("rem_ovf", {g0, g1}, 64'd0);
        run_op(XU_DIVU, 32'hFFFF_FFFF, 32'h10, 0, g0, g1);
        chk("divu", {g0, g1}, {32'h0FFF_FFFF, 32'h0FFF_FFFF});
        run_op(XU_DIV, 32'd5, 32'd0, 0, g0, g1);
        chk("div_z", {g0, g1}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        run_op(XU_REM, 32'd5, 32'd0, 0, g0, g1);
        chk("rem_z", {g0, g1}, {32'd5, 32'd5});
        run_op(XU_SHR, 32'h8000_0000, 32'd33, 0, g0, g1);
        chk("shr", {g0, g1}, {32'hC000_0000, 32'hC000_0000});
        run_op(XU_USHR, 32'h8000_0000, 32'd33, 0, g0, g1);
        chk("ushr", {g0, g1}, {32'h4000_0000, 32'h4000_0000});
        run_op(XU_SHL, 32'd1, 32'd31, 0, g0, g1);
        chk("shl", {g0, g1}, {32'h8000_0000, 32'h8000_0000});
        run_op(XU_MULH, 32'hFFFF_FFFE, 32'd3, 0, g0, g1);
        chk("mulh", {g0, g1}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        run_op(XU_MUL, 32'hFFFF_FFFE, 32'd3, 0, g0, g1);
        chk("mul", {g0, g1}, {32'hFFFF_FFFA, 32'hFFFF_FFFA});
        run_op(4'hC, 32'h1234_5678, 32'd9, 0, g0, g1);
        chk("unk_op", {g0, g1}, 64'd0);

        // A req pulse during bsy must be dropped, not queued.
        run_op(XU_DIV, 32'd100, 32'd7, 5, g0, g1);
        chk("busy_req", {g0, g1}, {32'd14, 32'd14});
        repeat (3) begin
            @(negedge clk);
            chk("no_queue", 64'({done0, done1}), 64'd0);
        end

        @(negedge clk);
        req = 1'b1; op = XU_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("kill_bsy_on", 64'({bsy0, bsy1}), 64'h3);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("kill_bsy_off", 64'({bsy0, bsy1}), 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            nd += int'(done0) + int'(done1);
        end
        chk("kill_nodone", 64'(nd), 64'd0);
        chk("kill_r", {r0, r1}, {32'd14, 32'd14});

        @(negedge clk);
        req = 1'b1; op = XU_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_bsy", 64'({bsy0, bsy1}), 64'd0);
        chk("mrst_r", {r0, r1}, 64'd0);
        chk("mrst_done", 64'({done0, done1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back shifts, one per cycle.
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                model(bo[i-1], bx[i-1], by[i-1], 1'b0, e, ed, lat);
                chk("b2b_done", 64'({done0, done1}), 64'h3);
                chk("b2b_r", {r0, r1}, {e, e});
            end
            if (i < 5) begin
                bo[i] = 4'(32'(XU_SHL) + $urandom_range(0, 2));
                bx[i] = $urandom;
                by[i] = $urandom;
                req = 1'b1; op = bo[i]; a = bx[i]; b = by[i];
            end else begin
                req = 1'b0;
            end
        end

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y;
            int          k;
            k = int'($urandom_range(0, 9));
            o = (k == 9) ? 4'hC : 4'(k);
            x = $urandom;
            k = int'($urandom_range(0, 7));
            if (k == 0)      y = 32'd0;
            else if (k < 3)  y = $urandom_range(1, 20);
            else if (k == 3) y = 32'hFFFF_FFFF - $urandom_range(0, 5);
            else             y = $urandom;
            run_op(o, x, y, 0, g0, g1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
